// File: rtl/fm_demod_core.sv
// Quadrature FM discriminator: interleaved I/Q bytes -> cross-product phase difference,
// decimating accumulator and saturating output. Optional de-emphasis via FM_DEMOD_DEEMPH_EN.
module fm_demod_core #(
  parameter int unsigned IN_W         = 8,
  parameter int unsigned OUT_W        = 16,
  parameter int unsigned DECIM        = 4,
  parameter int unsigned OUT_SHIFT    = 2,
  parameter int unsigned DEEMPH_SHIFT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  data_i,
  input  logic                    start_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    valid_o
);

  localparam int unsigned PROD_W = 2 * IN_W;
  localparam int unsigned DISC_W = 2 * IN_W + 1;
  localparam int unsigned ACC_W  = DISC_W + $clog2(DECIM);
  localparam int unsigned CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int unsigned Y_W    = OUT_W + DEEMPH_SHIFT;
  localparam int unsigned SAT_W  = ((ACC_W > Y_W) ? ACC_W : Y_W) + 1;

  localparam logic signed [SAT_W-1:0] OUT_MAX = SAT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SAT_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic {PH_I = 1'b0, PH_Q = 1'b1} phase_t;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SAT_W-1:0] v);
    if (v > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  phase_t                    phase_q, phase_d;
  logic signed [IN_W-1:0]    i_hold_q, i_hold_d;
  logic signed [IN_W-1:0]    i_cur_q, i_cur_d, q_cur_q, q_cur_d;
  logic signed [IN_W-1:0]    i_prev_q, i_prev_d, q_prev_q, q_prev_d;
  logic                      s0_v_q, s0_v_d;
  logic signed [PROD_W-1:0]  prod_a_q, prod_a_d, prod_b_q, prod_b_d;
  logic                      s1_v_q, s1_v_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      dump_v_q, dump_v_d;
  logic signed [OUT_W-1:0]   data_q, data_d;
  logic                      valid_q, valid_d;
  logic signed [DISC_W-1:0]  disc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [OUT_W-1:0]   dump_x;
`ifdef FM_DEMOD_DEEMPH_EN
  logic signed [Y_W-1:0]     y_q, y_d;
  logic                      y_v_q, y_v_d;
  logic signed [Y_W:0]       y_diff, y_step;
`endif

  assign data_o  = data_q;
  assign valid_o = valid_q;

  // Next-state: phase tracking, sample shift, multiply, accumulate/dump, output stage
  always_comb begin
    phase_d  = phase_q;
    i_hold_d = i_hold_q;
    i_cur_d  = i_cur_q;
    q_cur_d  = q_cur_q;
    i_prev_d = i_prev_q;
    q_prev_d = q_prev_q;
    s0_v_d   = 1'b0;
    prod_a_d = prod_a_q;
    prod_b_d = prod_b_q;
    s1_v_d   = 1'b0;
    acc_d    = acc_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    dump_v_d = 1'b0;
    data_d   = data_q;
    valid_d  = 1'b0;
    disc     = DISC_W'(prod_a_q) - DISC_W'(prod_b_q);
    acc_sum  = acc_q + ACC_W'(disc);
    dump_x   = sat_out(SAT_W'(sum_q >>> OUT_SHIFT));
`ifdef FM_DEMOD_DEEMPH_EN
    y_d      = y_q;
    y_v_d    = 1'b0;
    y_diff   = (Y_W + 1)'(dump_x) - (Y_W + 1)'(y_q);
    y_step   = y_diff >>> DEEMPH_SHIFT;
`endif

    if (phase_q == PH_I) begin
      i_hold_d = data_i;
      phase_d  = PH_Q;
    end else begin
      i_cur_d  = i_hold_q;
      q_cur_d  = data_i;
      i_prev_d = i_cur_q;
      q_prev_d = q_cur_q;
      s0_v_d   = 1'b1;
      phase_d  = PH_I;
    end

    if (s0_v_q) begin
      prod_a_d = PROD_W'(i_prev_q) * PROD_W'(q_cur_q);
      prod_b_d = PROD_W'(q_prev_q) * PROD_W'(i_cur_q);
      s1_v_d   = 1'b1;
    end

    // Last result of a block goes straight to the dump register so nothing is lost
    if (s1_v_q) begin
      if (cnt_q == CNT_W'(DECIM - 1)) begin
        sum_d    = acc_sum;
        acc_d    = '0;
        cnt_d    = '0;
        dump_v_d = 1'b1;
      end else begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

`ifdef FM_DEMOD_DEEMPH_EN
    if (dump_v_q) begin
      y_d   = y_q + Y_W'(y_step);
      y_v_d = 1'b1;
    end
    if (y_v_q) begin
      data_d  = sat_out(SAT_W'(y_q));
      valid_d = 1'b1;
    end
`else
    if (dump_v_q) begin
      data_d  = dump_x;
      valid_d = 1'b1;
    end
`endif

    // Idle: drop partial pair and in-flight results, keep last output sample
    if (!start_i) begin
      phase_d  = PH_I;
      i_hold_d = '0;
      i_cur_d  = '0;
      q_cur_d  = '0;
      i_prev_d = '0;
      q_prev_d = '0;
      s0_v_d   = 1'b0;
      s1_v_d   = 1'b0;
      acc_d    = '0;
      cnt_d    = '0;
      dump_v_d = 1'b0;
      data_d   = data_q;
      valid_d  = 1'b0;
`ifdef FM_DEMOD_DEEMPH_EN
      y_d      = '0;
      y_v_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q  <= PH_I;
      i_hold_q <= '0;
      i_cur_q  <= '0;
      q_cur_q  <= '0;
      i_prev_q <= '0;
      q_prev_q <= '0;
      s0_v_q   <= 1'b0;
      prod_a_q <= '0;
      prod_b_q <= '0;
      s1_v_q   <= 1'b0;
      acc_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      dump_v_q <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
`ifdef FM_DEMOD_DEEMPH_EN
      y_q      <= '0;
      y_v_q    <= 1'b0;
`endif
    end else begin
      phase_q  <= phase_d;
      i_hold_q <= i_hold_d;
      i_cur_q  <= i_cur_d;
      q_cur_q  <= q_cur_d;
      i_prev_q <= i_prev_d;
      q_prev_q <= q_prev_d;
      s0_v_q   <= s0_v_d;
      prod_a_q <= prod_a_d;
      prod_b_q <= prod_b_d;
      s1_v_q   <= s1_v_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      dump_v_q <= dump_v_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
`ifdef FM_DEMOD_DEEMPH_EN
      y_q      <= y_d;
      y_v_q    <= y_v_d;
`endif
    end
  end

endmodule

// File: tb/tb_fm_demod_core.sv
// Directed vector bench for fm_demod_core (default build, de-emphasis macro undefined).
module tb_fm_demod_core;

  logic clk;
  logic rst_n;
  logic start;
  logic signed [7:0]  din;
  logic signed [15:0] d1_data, d4_data;
  logic signed [7:0]  sat_data;
  logic d1_v, d4_v, sat_v;

  int checks;
  int failures;

  typedef struct {
    bit start;
    int din;
    bit exp_valid;
    int exp_data;
  } vec_t;

  vec_t vq[$];

  fm_demod_core #(.DECIM(1)) u_d1 (
    .clk(clk), .rst(rst_n), .data_i(din), .start_i(start), .data_o(d1_data), .valid_o(d1_v));
  fm_demod_core u_d4 (
    .clk(clk), .rst(rst_n), .data_i(din), .start_i(start), .data_o(d4_data), .valid_o(d4_v));
  fm_demod_core #(.OUT_W(8), .DECIM(1)) u_sat (
    .clk(clk), .rst(rst_n), .data_i(din), .start_i(start), .data_o(sat_data), .valid_o(sat_v));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input bit s, input int d, input bit v, input int e);
    vec_t r;
    r.start = s; r.din = d; r.exp_valid = v; r.exp_data = e;
    vq.push_back(r);
  endtask

  task automatic get_out(input int sel, output bit v, output int d);
    case (sel)
      0:       begin v = d1_v;  d = int'(d1_data);  end
      1:       begin v = d4_v;  d = int'(d4_data);  end
      default: begin v = sat_v; d = int'(sat_data); end
    endcase
  endtask

  task automatic check(input string name, input int idx, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s[%0d] got %0d want %0d", name, idx, got, want);
    end
  endtask

  task automatic run_vecs(input int sel, input string name);
    bit v;
    int d;
    foreach (vq[i]) begin
      start = vq[i].start;
      din   = 8'(vq[i].din);
      @(posedge clk);
      #1;
      get_out(sel, v, d);
      check({name, "_valid"}, i, int'(v), int'(vq[i].exp_valid));
      check({name, "_data"}, i, d, vq[i].exp_data);
    end
    vq.delete();
  endtask

  task automatic check_all_zero(input string name);
    bit v;
    int d;
    for (int s = 0; s < 3; s++) begin
      get_out(s, v, d);
      check({name, "_valid"}, s, int'(v), 0);
      check({name, "_data"}, s, d, 0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pat[8];
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    din      = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // DECIM=1 basic: pair (64,0) then (0,64)
    add(1, 64, 0, 0);    add(1, 0, 0, 0);    add(1, 0, 0, 0);    add(1, 64, 0, 0);
    add(1, 0, 1, 0);     add(1, 0, 0, 0);    add(1, 0, 1, 1024); add(1, 0, 0, 1024);
    add(1, 0, 1, 0);
    run_vecs(0, "dec1");

    // DECIM=4 rotating phasor, continuous output every 8 cycles
    do_reset();
    pat = '{64, 0, 0, 64, -64, 0, 0, -64};
    for (int v = 0; v < 28; v++) begin
      add(1'b1, pat[v % 8], (v == 10) || (v == 18) || (v == 26),
          (v < 10) ? 0 : ((v < 18) ? 3072 : 4096));
    end
    run_vecs(1, "dec4");

    // OUT_W=8 positive then negative saturation
    do_reset();
    add(1, -128, 0, 0);  add(1, 0, 0, 0);    add(1, 0, 0, 0);    add(1, -128, 0, 0);
    add(1, -128, 1, 0);  add(1, 0, 0, 0);    add(1, 0, 1, 127);  add(1, 0, 0, 127);
    add(1, 0, 1, -128);  add(1, 0, 0, -128); add(1, 0, 1, 0);
    run_vecs(2, "sat");

    // start_i drop after an I byte: pending I and in-flight result discarded
    do_reset();
    add(1, 64, 0, 0);    add(1, 0, 0, 0);    add(1, 0, 0, 0);    add(1, 64, 0, 0);
    add(1, 64, 1, 0);    add(1, 0, 0, 0);    add(1, 64, 1, 1024); add(0, 99, 0, 1024);
    add(1, 0, 0, 1024);  add(1, 64, 0, 1024); add(1, 0, 0, 1024); add(1, 0, 0, 1024);
    add(1, 0, 1, 0);
    run_vecs(0, "drop");

    // Reset mid-stream with two results in flight
    do_reset();
    add(1, 64, 0, 0);    add(1, 0, 0, 0);    add(1, 0, 0, 0);    add(1, 64, 0, 0);
    add(1, 0, 1, 0);     add(1, 0, 0, 0);    add(1, 0, 1, 1024); add(1, 0, 0, 1024);
    run_vecs(0, "pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 0, int'(d1_v), 0);
    check("midrst_data", 0, int'(d1_data), 0);
    repeat (2) @(posedge clk);
    #1;
    check("inrst_valid", 0, int'(d1_v), 0);
    check("inrst_data", 0, int'(d1_data), 0);
    rst_n = 1'b1;
    add(1, 64, 0, 0);    add(1, 0, 0, 0);    add(1, 0, 0, 0);    add(1, 0, 0, 0);
    add(1, 0, 1, 0);
    run_vecs(0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
